// File: rtl/match_phase_row_sched_pkg.sv
// pmp_pkg: shared types and sizing helpers for the match_phase
// row-pair scheduler.
package pmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW0,
    S_GAP,
    S_ROW1,
    S_DRAIN0,
    S_DRAIN1,
    S_WAIT_RES
  } sched_state_e;

  function automatic int row_beats(
    input int row_size,
    input int beat_size
  );
    return row_size / beat_size;
  endfunction

  function automatic int beat_width(
    input int beat_size,
    input int data_width
  );
    return beat_size * data_width;
  endfunction

endpackage

// File: rtl/match_phase_row_sched_if.sv
// Stream bundle around the row-pair scheduler: two row sources,
// the match_phase input stream and the result-stream monitor taps.
interface match_phase_row_sched_if #(
  parameter int BEAT_WIDTH = 128
);

  logic [BEAT_WIDTH-1:0] s0_axis_tdata;
  logic                  s0_axis_tvalid;
  logic                  s0_axis_tready;
  logic                  s0_axis_tlast;

  logic [BEAT_WIDTH-1:0] s1_axis_tdata;
  logic                  s1_axis_tvalid;
  logic                  s1_axis_tready;
  logic                  s1_axis_tlast;

  logic [BEAT_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  logic                  res_tvalid;
  logic                  res_tready;
  logic                  res_tlast;

  modport master (
    output s0_axis_tdata,
    output s0_axis_tvalid,
    input  s0_axis_tready,
    output s0_axis_tlast,
    output s1_axis_tdata,
    output s1_axis_tvalid,
    input  s1_axis_tready,
    output s1_axis_tlast,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    output res_tvalid,
    output res_tready,
    output res_tlast
  );

  modport slave (
    input  s0_axis_tdata,
    input  s0_axis_tvalid,
    output s0_axis_tready,
    input  s0_axis_tlast,
    input  s1_axis_tdata,
    input  s1_axis_tvalid,
    output s1_axis_tready,
    input  s1_axis_tlast,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    input  res_tvalid,
    input  res_tready,
    input  res_tlast
  );

endinterface

// File: rtl/match_phase_row_sched.sv
// Serialises reference/target row pairs into match_phase, enforcing
// row length and optionally holding off until the result row ends.
module match_phase_row_sched
  import pmp_pkg::*;
#(
  parameter int ROW_SIZE    = 1280,
  parameter int BEAT_SIZE   = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int WAIT_RESULT = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  match_phase_row_sched_if.slave bus,
  output logic        busy,
  output logic        err_short,
  output logic        err_long,
  output logic [15:0] pair_cnt
);

  localparam int RB = row_beats(ROW_SIZE, BEAT_SIZE);
  localparam int BW = beat_width(BEAT_SIZE, DATA_WIDTH);
  localparam int CW = (RB > 1) ? $clog2(RB) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] BEAT_LAST = CW'(RB - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GL);

  localparam sched_state_e AFTER0 =
    (GAP_CYCLES == 0) ? S_ROW1 : S_GAP;
  localparam sched_state_e AFTER1 =
    (WAIT_RESULT != 0) ? S_WAIT_RES : S_IDLE;

  sched_state_e state, state_nx;

  logic [CW-1:0] beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic          res_seen;

  logic          sel1;
  logic          in_row;
  logic          in_drain;
  logic [BW-1:0] sel_tdata;
  logic          sel_tvalid;
  logic          sel_tlast;
  logic          beat_last;
  logic          m_hs;
  logic          row_end;
  logic          end_long;
  logic          end_short;
  logic          drain_end;
  logic          res_done;
  logic          gap_done;
  logic          pair_done;

  assign sel1     = state inside {S_ROW1, S_DRAIN1};
  assign in_row   = state inside {S_ROW0, S_ROW1};
  assign in_drain = state inside {S_DRAIN0, S_DRAIN1};

  assign sel_tdata  = sel1 ? bus.s1_axis_tdata
                           : bus.s0_axis_tdata;
  assign sel_tvalid = sel1 ? bus.s1_axis_tvalid
                           : bus.s0_axis_tvalid;
  assign sel_tlast  = sel1 ? bus.s1_axis_tlast
                           : bus.s0_axis_tlast;

  assign beat_last = beat_cnt == BEAT_LAST;
  assign m_hs      = in_row & sel_tvalid & bus.m_axis_tready;
  assign row_end   = m_hs & (sel_tlast | beat_last);
  assign end_long  = row_end & beat_last & ~sel_tlast;
  assign end_short = row_end & sel_tlast & ~beat_last;
  assign drain_end = in_drain & sel_tvalid & sel_tlast;
  assign gap_done  = gap_cnt == GAP_LAST;

  assign res_done = bus.res_tvalid & bus.res_tready
                  & bus.res_tlast;

  assign pair_done =
    ((state == S_ROW1) & row_end & ~end_long) |
    ((state == S_DRAIN1) & drain_end);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (enable) state_nx = S_ROW0;
      S_ROW0:
        if (end_long)     state_nx = S_DRAIN0;
        else if (row_end) state_nx = AFTER0;
      S_DRAIN0:
        if (drain_end) state_nx = AFTER0;
      S_GAP:
        if (gap_done) state_nx = S_ROW1;
      S_ROW1:
        if (end_long)     state_nx = S_DRAIN1;
        else if (row_end) state_nx = AFTER1;
      S_DRAIN1:
        if (drain_end) state_nx = AFTER1;
      S_WAIT_RES:
        if (res_done | res_seen) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.m_axis_tdata   = '0;
    bus.m_axis_tvalid  = 1'b0;
    bus.m_axis_tlast   = 1'b0;
    bus.s0_axis_tready = 1'b0;
    bus.s1_axis_tready = 1'b0;
    busy               = state != S_IDLE;
    unique case (1'b1)
      in_row: begin
        bus.m_axis_tdata   = sel_tdata;
        bus.m_axis_tvalid  = sel_tvalid;
        bus.m_axis_tlast   = sel_tlast | beat_last;
        bus.s0_axis_tready = ~sel1 & bus.m_axis_tready;
        bus.s1_axis_tready =  sel1 & bus.m_axis_tready;
      end
      in_drain: begin
        bus.s0_axis_tready = ~sel1;
        bus.s1_axis_tready =  sel1;
      end
      default: ;
    endcase
  end

  // beat_cnt restarts at every row end, including forced ends
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      res_seen  <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      if (row_end)   beat_cnt <= '0;
      else if (m_hs) beat_cnt <= beat_cnt + 1'b1;

      if (state != S_GAP) gap_cnt <= '0;
      else if (gap_done)  gap_cnt <= '0;
      else                gap_cnt <= gap_cnt + 1'b1;

      if (state == S_WAIT_RES)
        res_seen <= 1'b0;
      else if (res_done && sel1 && WAIT_RESULT != 0)
        res_seen <= 1'b1;

      if (end_short) err_short <= 1'b1;
      if (end_long)  err_long  <= 1'b1;
      if (pair_done) pair_cnt  <= pair_cnt + 16'd1;
    end
  end

endmodule
